// File: rtl/ram_reader.sv
// rtl/ram_reader.sv - burst reader from an async-read RAM into a ready/valid word stream
module ram_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic [ADDR_WIDTH-1:0] remaining, remaining_nxt;
    logic [DATA_WIDTH-1:0] out_data_nxt;
    logic                  out_valid_nxt;
    logic                  out_last_nxt;
    logic                  done_nxt;
    logic                  transfer;
    logic                  fetch;

    assign transfer = out_valid & out_ready;
    // Output register refills when empty or being drained this cycle.
    assign fetch    = (remaining != '0) & (~out_valid | out_ready);
    assign busy     = (state == STREAM);

    always_comb begin
        state_nxt     = state;
        mem_addr_nxt  = mem_addr;
        remaining_nxt = remaining;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        out_last_nxt  = out_last;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        mem_addr_nxt  = base_addr;
                        remaining_nxt = length;
                        state_nxt     = STREAM;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (abort) begin
                    out_valid_nxt = 1'b0;
                    out_last_nxt  = 1'b0;
                    state_nxt     = IDLE;
                end else if (transfer && out_last) begin
                    out_valid_nxt = 1'b0;
                    out_last_nxt  = 1'b0;
                    done_nxt      = 1'b1;
                    state_nxt     = IDLE;
                end else if (fetch) begin
                    out_data_nxt  = mem_data;
                    out_valid_nxt = 1'b1;
                    out_last_nxt  = (remaining == ADDR_WIDTH'(1));
                    mem_addr_nxt  = mem_addr + ADDR_WIDTH'(1);
                    remaining_nxt = remaining - ADDR_WIDTH'(1);
                end else if (transfer) begin
                    out_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_addr  <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_addr  <= mem_addr_nxt;
            remaining <= remaining_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
            out_last  <= out_last_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_ram_reader.sv
// tb/tb_ram_reader.sv - self-checking bench for ram_reader against a queue-based burst model
module tb_ram_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] length;
    logic       abort;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       done;

    logic [7:0] mem [256];
    int         ncmp  = 0;
    int         nfail = 0;

    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr];

    ram_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    // mode: 0 = ready always high, 1 = fixed ready pattern, 2 = random ready.
    task automatic run_burst(input logic [7:0] base, input logic [7:0] len, input int mode,
                             input int abort_at, input bit noise);
        logic [7:0] exp_q [$];
        logic [7:0] a;
        logic [6:0] pat = 7'b1101001;
        logic [7:0] prev_data, prev_addr;
        logic       prev_last, prev_stall, aborted;
        int         got, cyc, dones;
        for (int i = 0; i < int'(len); i++) begin
            a = base + 8'(i);
            exp_q.push_back(mem[a]);
        end
        start = 1'b1; base_addr = base; length = len;
        @(negedge clk);
        start = 1'b0; base_addr = $urandom; length = $urandom;
        check("accept_busy", busy, 1);
        check("accept_no_valid", out_valid, 0);
        got = 0; cyc = 0; dones = 0; prev_stall = 0; aborted = 0;
        prev_data = 0; prev_last = 0; prev_addr = 0;
        while (got < int'(len) && !aborted && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (done) dones++;
            if (abort_at != 0 && got == abort_at) begin
                abort = 1'b1;
                aborted = 1'b1;
            end else begin
                if (noise) begin
                    start = 1'($urandom); base_addr = $urandom; length = $urandom;
                end
                case (mode)
                    0: out_ready = 1'b1;
                    1: out_ready = (cyc <= 7) ? pat[cyc-1] : 1'b1;
                    default: out_ready = 1'($urandom);
                endcase
                if (cyc == 1) begin
                    check("first_beat_valid", out_valid, 1);
                    check("first_beat_data", out_data, exp_q[0]);
                end
                if (prev_stall) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, prev_data);
                    check("stall_last", out_last, prev_last);
                    check("stall_addr", mem_addr, prev_addr);
                end
                if (out_valid && out_ready) begin
                    check("beat_data", out_data, exp_q[got]);
                    check("beat_last", out_last, (got == int'(len) - 1));
                    got++;
                end
                prev_stall = out_valid && !out_ready;
                prev_data = out_data; prev_last = out_last; prev_addr = mem_addr;
            end
        end
        check("early_done", dones, 0);
        if (aborted) begin
            @(negedge clk);
            abort = 1'b0;
            check("abort_valid", out_valid, 0);
            check("abort_last", out_last, 0);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("post_abort_quiet", {done, out_valid, busy}, 0);
            end
        end else begin
            check("burst_beats", got, len);
            if (mode == 0) check("throughput_cycles", cyc, len);
            @(negedge clk);
            start = 1'b0;
            check("done_pulse", done, 1);
            check("done_busy", busy, 0);
            check("done_valid", out_valid, 0);
            check("end_addr", mem_addr, 8'(base + len));
            @(negedge clk);
            check("done_single", done, 0);
            check("end_addr_hold", mem_addr, 8'(base + len));
        end
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] hold_addr;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        base_addr = 8'h0; length = 8'h0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        @(negedge clk);
        check("reset_outputs", {mem_addr, out_data, out_valid, out_last, busy, done}, 0);
        rst_n = 1'b1;

        run_burst(8'h10, 8'd4, 0, 0, 1'b0);
        run_burst(8'hFE, 8'd3, 0, 0, 1'b0);
        run_burst(8'h33, 8'd4, 1, 0, 1'b0);

        hold_addr = mem_addr;
        start = 1'b1; base_addr = 8'h77; length = 8'd0; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        check("len0_valid", out_valid, 0);
        check("len0_addr", mem_addr, hold_addr);
        @(negedge clk);
        check("len0_done_single", done, 0);
        check("len0_quiet", {out_valid, busy}, 0);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_noop", {done, out_valid, busy}, 0);

        run_burst(8'h20, 8'd8, 0, 2, 1'b0);
        run_burst(8'h40, 8'd1, 0, 0, 1'b0);

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 8; k++) mem[$urandom_range(255, 0)] = 8'($urandom);
            run_burst(8'($urandom), 8'($urandom_range(40, 1)), (n % 2 == 0) ? 2 : 0, 0, 1'(n % 3 != 0));
        end

        start = 1'b1; base_addr = 8'h80; length = 8'd8;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b1; start = 1'b1; base_addr = 8'h05; length = 8'd2;
            @(negedge clk);
        end
        check("pre_reset_busy", busy, 1);
        start = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {mem_addr, out_data, out_valid, out_last, busy, done}, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_quiet", {done, out_valid, busy}, 0);
        end
        run_burst(8'h05, 8'd2, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
